// File: rtl/mp_arb_pkg.sv
// Shared definitions for the memory bus arbiter.
//   state_t      : arbiter FSM states (IDLE, ACCESS, RESP)
//   OWN_FETCH/OWN_DATA : owner encoding for the port that holds the bus
//   other_owner(): returns the opposite owner, used for tie alternation
package mp_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  function automatic logic other_owner(input logic owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory bus arbiter.
// Ports:
//   f_req, d_req : pending requests from the fetch and data ports
//   last_owner   : port granted most recently (OWN_FETCH / OWN_DATA)
//   owner        : selected port (meaningful only when any is high)
//   any          : at least one request pending
// A tie goes to the port that was not granted last. Tying last_owner to
// OWN_FETCH therefore gives fixed data-port priority.
module arb_pick
  import mp_arb_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_owner,
  output logic owner,
  output logic any
);

  always_comb begin
    any   = f_req | d_req;
    owner = OWN_FETCH;
    if (f_req && d_req) begin
      owner = other_owner(last_owner);
    end else if (d_req) begin
      owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter (fetch + data) in front of a single-port synchronous memory.
// Each access takes ACCESS (grant + memory strobe) then RESP (valid + data).
// A request pending in RESP starts the next ACCESS directly, giving one
// access every two cycles at peak.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   f_req/f_addr -> f_gnt/f_valid/f_rdata           : fetch (read-only) port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_valid/d_rdata : data port
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata     : memory side
//   busy      : FSM not in IDLE
//   dbg_state : current FSM state (debug visibility)
// Handshake: a requester holds req (and its address/data) until it sees its
// gnt pulse; the request is latched at the edge that produces gnt, so later
// input changes do not affect that access. valid pulses one cycle after gnt.
// Configuration macro ARB_ROUND_ROBIN_EN: when defined, ties alternate between
// ports; when undefined, the data port always wins a tie.
module mem_bus_arbiter
  import mp_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  state_t            state;
  logic              owner_q;
  logic              acc_we_q;
  logic [DATA_W-1:0] f_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              last_owner;
  logic              pick_owner;
  logic              pick_any;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;
  logic launch;

  // A new access can start from IDLE or straight out of RESP.
  assign launch     = pick_any && ((state == ST_IDLE) || (state == ST_RESP));
  assign last_owner = last_owner_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_q <= OWN_FETCH;
    end else if (launch) begin
      last_owner_q <= pick_owner;
    end
  end
`else
  // Pretending fetch always went last makes every tie go to the data port.
  assign last_owner = OWN_FETCH;
`endif

  arb_pick u_pick (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_owner (last_owner),
    .owner      (pick_owner),
    .any        (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner_q   <= OWN_FETCH;
      acc_we_q  <= 1'b0;
      f_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      f_valid   <= 1'b0;
      d_valid   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      f_gnt   <= 1'b0;
      d_gnt   <= 1'b0;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        ST_ACCESS: begin
          state <= ST_RESP;
          if (owner_q == OWN_DATA) begin
            d_valid <= 1'b1;
          end else begin
            f_valid <= 1'b1;
          end
        end
        ST_IDLE, ST_RESP: begin
          // Leaving RESP: keep the returned read data for the owning port.
          if (state == ST_RESP) begin
            if (owner_q == OWN_FETCH) begin
              f_rdata_q <= mem_rdata;
            end else if (!acc_we_q) begin
              d_rdata_q <= mem_rdata;
            end
          end
          if (pick_any) begin
            state   <= ST_ACCESS;
            owner_q <= pick_owner;
            mem_en  <= 1'b1;
            if (pick_owner == OWN_DATA) begin
              acc_we_q  <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              d_gnt     <= 1'b1;
            end else begin
              // Fetch is read-only: mem_we stays low.
              acc_we_q <= 1'b0;
              mem_addr <= f_addr;
              f_gnt    <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory data arrives during RESP; show it on the owner's port in that same
  // cycle, otherwise present the last value returned to that port.
  assign f_rdata = ((state == ST_RESP) && (owner_q == OWN_FETCH)) ? mem_rdata : f_rdata_q;
  assign d_rdata = ((state == ST_RESP) && (owner_q == OWN_DATA) && !acc_we_q) ?
                   mem_rdata : d_rdata_q;

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       f_req, f_gnt, f_valid;
  logic [7:0] f_addr, f_rdata;
  logic       d_req, d_we, d_gnt, d_valid;
  logic [7:0] d_addr, d_wdata, d_rdata;
  logic       mem_en, mem_we, busy;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0] dbg_state;
  logic       init_mem;

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rdata(f_rdata), .f_valid(f_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [7:0] mem_init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : 8'(a * 37 + 11);
  endfunction

  // Synchronous single-port memory: read data one cycle after mem_en.
  logic [7:0] tb_mem [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= mem_init_val(8'(i));
    end else if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      mem_rdata <= tb_mem[mem_addr];
    end
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic       port;      // 0 fetch, 1 data
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] exp_f, exp_d;

  task automatic do_vec(input vec_t v);
    @(negedge clk);
    if (v.port) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      f_req = 1'b1; f_addr = v.addr;
    end
    @(negedge clk);
    check("vec_gnt", {f_gnt, d_gnt}, v.port ? 2'b01 : 2'b10);
    check("vec_mem_ctl", {mem_en, mem_we, busy}, {1'b1, v.we, 1'b1});
    check("vec_mem_addr", mem_addr, v.addr);
    if (v.we) check("vec_mem_wdata", mem_wdata, v.wdata);
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    d_addr = 8'hEE; d_wdata = 8'hEE; f_addr = 8'hEE;
    @(negedge clk);
    check("vec_valid", {f_valid, d_valid}, v.port ? 2'b01 : 2'b10);
    check("vec_resp_quiet", {f_gnt, d_gnt, mem_en}, 3'b000);
    if (!v.we) begin
      if (v.port) exp_d = v.exp_rdata;
      else        exp_f = v.exp_rdata;
    end
    check("vec_rdata", {f_rdata, d_rdata}, {exp_f, exp_d});
    @(negedge clk);
    check("vec_idle", {busy, f_valid, d_valid, mem_en}, 4'b0000);
    check("vec_rdata_hold", {f_rdata, d_rdata}, {exp_f, exp_d});
  endtask

  task automatic check_all_zero(input string name);
    check(name, {f_gnt, d_gnt, f_valid, d_valid, mem_en, mem_we, busy, dbg_state,
                 f_rdata, d_rdata, mem_addr, mem_wdata}, 0);
  endtask

  // ---------------- reference model (transaction pipeline) ----------------
  typedef struct {
    logic       v;
    logic       own;   // 0 fetch, 1 data
    logic       we;
    logic [7:0] rd;
  } acc_t;

  acc_t       m_acc, m_resp;
  logic [7:0] ref_mem [256];
  logic [7:0] m_addr, m_wdata, m_frd, m_drd;
  logic       m_last;

  // Applies the effect of the edge just past, using the inputs that were
  // presented to it. An access started at one edge occupies the next cycle,
  // so a new one may start only if none started at the previous edge.
  task automatic model_edge();
    logic win;
    if (rst) begin
      m_acc = '{default: 0}; m_resp = '{default: 0};
      m_addr = 0; m_wdata = 0; m_frd = 0; m_drd = 0; m_last = 1'b0;
      return;
    end
    m_resp = m_acc;
    if (m_resp.v && !m_resp.we) begin
      if (m_resp.own) m_drd = m_resp.rd;
      else            m_frd = m_resp.rd;
    end
    m_acc = '{default: 0};
    if ((f_req || d_req) && !m_resp.v) begin
      if (f_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        win = ~m_last;
`else
        win = 1'b1;
`endif
      end else begin
        win = d_req;
      end
      m_last    = win;
      m_acc.v   = 1'b1;
      m_acc.own = win;
      m_acc.we  = win & d_we;
      m_addr    = win ? d_addr : f_addr;
      if (win) m_wdata = d_wdata;
      if (m_acc.we) ref_mem[m_addr] = d_wdata;
      else          m_acc.rd = ref_mem[m_addr];
    end
  endtask

  // ---------------- stimulus ----------------
  logic [1:0] seq [4];
  int         ng, g1, g2;
  logic       saw;

  initial begin
    vecs[0] = '{port: 1'b0, we: 1'b0, addr: 8'h10, wdata: 8'h00, exp_rdata: 8'hA5};
    vecs[1] = '{port: 1'b1, we: 1'b1, addr: 8'h20, wdata: 8'h3C, exp_rdata: 8'h00};
    vecs[2] = '{port: 1'b1, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[3] = '{port: 1'b0, we: 1'b0, addr: 8'h20, wdata: 8'h00, exp_rdata: 8'h3C};
    vecs[4] = '{port: 1'b1, we: 1'b1, addr: 8'hFF, wdata: 8'h5A, exp_rdata: 8'h00};
    vecs[5] = '{port: 1'b0, we: 1'b0, addr: 8'hFF, wdata: 8'h00, exp_rdata: 8'h5A};
    vecs[6] = '{port: 1'b1, we: 1'b0, addr: 8'h01, wdata: 8'h00, exp_rdata: 8'h30};

    rst = 1'b1; init_mem = 1'b1;
    f_req = 0; f_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    exp_f = 0; exp_d = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0; init_mem = 1'b0;

    for (int i = 0; i < 7; i++) do_vec(vecs[i]);

    // Tie: both ports held. Fresh reset so the first tie goes to data.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    f_req = 1; f_addr = 8'h40; d_req = 1; d_we = 0; d_addr = 8'h41;
`ifdef ARB_ROUND_ROBIN_EN
    seq[0] = 2'b01; seq[1] = 2'b10; seq[2] = 2'b01; seq[3] = 2'b10;
`else
    seq[0] = 2'b01; seq[1] = 2'b01; seq[2] = 2'b01; seq[3] = 2'b01;
`endif
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      @(negedge clk);
      if (f_gnt || d_gnt) begin
        check($sformatf("tie_grant%0d", ng), {f_gnt, d_gnt}, seq[ng]);
        ng++;
      end
    end
    check("tie_grant_count", ng, 4);
    f_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    // Back-to-back data reads: second grant two cycles after the first.
    d_req = 1; d_we = 0; d_addr = 8'h20;
    ng = 0; g1 = -1; g2 = -1; saw = 1'b0;
    for (int c = 0; c < 12 && ng < 2; c++) begin
      @(negedge clk);
      if (ng == 1 && !busy) saw = 1'b1;
      if (d_gnt) begin
        if (ng == 0) g1 = c; else g2 = c;
        ng++;
        if (ng == 2) d_req = 0;
      end
    end
    check("b2b_gap", g2 - g1, 2);
    check("b2b_no_idle", saw, 1'b0);
    repeat (3) @(negedge clk);
    exp_d = 8'h3C;
    check("b2b_rdata", d_rdata, exp_d);

    // Fetch request raised only while busy and dropped before any grant.
    d_req = 1; d_we = 0; d_addr = 8'h30;
    @(negedge clk); d_req = 0; f_req = 1; f_addr = 8'h31;
    @(negedge clk); f_req = 0;
    saw = 1'b0;
    repeat (4) begin @(negedge clk); saw = saw | f_gnt | f_valid; end
    check("dropped_req_ignored", saw, 1'b0);

    // Reset during ACCESS abandons the access.
    f_req = 1; f_addr = 8'h10;
    @(negedge clk);
    check("rst_acc_gnt", f_gnt, 1'b1);
    rst = 1'b1; f_req = 0;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("rst_in_access");
    @(negedge clk);
    check("rst_no_valid", {f_valid, d_valid, busy}, 3'b000);

    // Randomized phase against the reference model.
    @(negedge clk); rst = 1'b1; init_mem = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init_val(8'(i));
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      model_edge();
      init_mem = 1'b0;
      check("rnd_ctl", {f_gnt, d_gnt, mem_en, mem_we, f_valid, d_valid, busy},
            {m_acc.v & ~m_acc.own, m_acc.v & m_acc.own, m_acc.v, m_acc.we,
             m_resp.v & ~m_resp.own, m_resp.v & m_resp.own, m_acc.v | m_resp.v});
      check("rnd_mem_bus", {mem_addr, mem_wdata}, {m_addr, m_wdata});
      check("rnd_rdata", {f_rdata, d_rdata}, {m_frd, m_drd});
      rst = ($urandom_range(0, 99) == 0);
      // Requesters: hold until granted (occasionally give up), then maybe re-request.
      if (f_req && !f_gnt) f_req = ($urandom_range(0, 19) != 0);
      else if (!f_req || f_gnt) begin
        f_req  = ($urandom_range(0, 2) == 0);
        f_addr = 8'($urandom_range(0, 15));
      end
      if (d_req && !d_gnt) d_req = ($urandom_range(0, 19) != 0);
      else if (!d_req || d_gnt) begin
        d_req   = ($urandom_range(0, 1) == 0);
        d_we    = $urandom_range(0, 1);
        d_addr  = 8'($urandom_range(0, 15));
        d_wdata = 8'($urandom_range(0, 255));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
- REQ-001 Parameter ADDR_W, default 8: memory address width.
- REQ-002 Parameter DATA_W, default 8: memory data width.
- REQ-003 clk  in  1  single clock; all state changes on rising edge.
- REQ-004 rst  in  1  reset, synchronous, active-high.
- REQ-005 f_req  in  1  fetch-port read request; held until f_gnt.
- REQ-006 f_addr  in  ADDR_W  fetch address; stable while f_req high.
- REQ-007 f_gnt  out  1  one-cycle pulse: fetch request accepted.
- REQ-008 f_rdata  out  DATA_W  fetch read data; valid when f_valid high.
- REQ-009 f_valid  out  1  one-cycle pulse: fetch data returned.
- REQ-010 d_req  in  1  data-port request; held until d_gnt.
- REQ-011 d_we  in  1  data-port write (1) / read (0).
- REQ-012 d_addr  in  ADDR_W  data-port address.
- REQ-013 d_wdata  in  DATA_W  data-port write data.
- REQ-014 d_gnt  out  1  one-cycle pulse: data request accepted.
- REQ-015 d_rdata  out  DATA_W  data read data; valid when d_valid high.
- REQ-016 d_valid  out  1  one-cycle pulse: read data returned or write completed.
- REQ-017 mem_en, mem_we  out  1 each  single-port memory enable / write strobe.
- REQ-018 mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W  memory address / write data.
- REQ-019 mem_rdata  in  DATA_W  memory read data, one cycle after mem_en.
- REQ-020 busy  out  1  high whenever state is not IDLE.

Function
- REQ-021 The FSM SHALL have states IDLE, ACCESS, RESP.
- REQ-022 IDLE: any req high at edge -> latch winner's addr/we/wdata, go ACCESS; no req -> stay IDLE.
- REQ-023 ACCESS (one cycle): mem_en=1, mem_we/mem_addr/mem_wdata from latched request, winner's gnt=1; go RESP.
- REQ-024 RESP (one cycle): mem_rdata captured into winner's rdata; winner's valid=1; then IDLE, or directly ACCESS if a req is pending (same selection rule).
- REQ-025 Latency SHALL be req sampled at edge N -> gnt in cycle N+1 -> valid in cycle N+2; peak throughput one access per 2 cycles.
- REQ-026 Fetch port SHALL never drive mem_we=1.
- REQ-027 Default (macro absent): simultaneous requests -> data port wins.
- REQ-028 rdata outputs SHALL hold last returned value until next valid for that port.
- REQ-029 A req dropped before its gnt SHALL be ignored without error; inputs changed after latching SHALL not affect the access.
- REQ-030 Outputs mem_en, mem_we, gnt, valid SHALL be 0 in IDLE; exactly one gnt and one valid per accepted request.

Reset
- REQ-031 rst SHALL force IDLE; all outputs 0 (rdata, mem_addr, mem_wdata included) on the next edge.
- REQ-032 rst during ACCESS/RESP SHALL abandon the access; no valid pulse follows; requesters re-request.
- REQ-033 Round-robin last-owner flag SHALL reset to "fetch" (data wins first tie).

Configuration
- REQ-034 Macro ARB_ROUND_ROBIN_EN defined: ties alternate; winner is the port not granted last.
- REQ-035 Macro undefined: fixed priority per REQ-027; no last-owner flag is built.

Structure
- REQ-036 Shared package mp_arb_pkg SHALL hold the state enum and owner encoding (OWN_FETCH=0, OWN_DATA=1).
- REQ-037 Winner selection SHALL be a sub-module arb_pick (combinational: f_req, d_req, last_owner -> owner, any).

Verification
- REQ-038 Fetch only: f_req=1, f_addr=0x10, mem holds 0xA5 -> f_gnt cycle N+1, f_valid+f_rdata=0xA5 cycle N+2.
- REQ-039 Data write: d_req=1, d_we=1, d_addr=0x20, d_wdata=0x3C -> mem_we=1, mem_addr=0x20 in ACCESS; d_valid cycle N+2; readback gives 0x3C.
- REQ-040 Tie, macro off: both req held 3 accesses -> grants D,D,D; fetch starves while d_req high.
- REQ-041 Tie, ARB_ROUND_ROBIN_EN: both req held 4 accesses -> grants D,F,D,F.
- REQ-042 rst asserted in ACCESS -> next cycle IDLE, busy=0, no valid pulse; outputs all 0.
- REQ-043 Back-to-back: d_req held for 2 reads -> grants at N+1 and N+3, no IDLE cycle between.
